fb_read_cmd_split: RTL and testbench
====================================

// Module: fb_read_cmd_split
// PURPOSE
//  Downstream of fb_packet_divide in the frame-buffer read path. Each packet read request
//  (i_aval, iv_rd_addr, iv_rd_length) is cut into memory read burst commands.
//  A burst never exceeds BURST_MAX_BYTES and never crosses a BOUNDARY_BYTES address boundary.
//  o_ardy is the ready that fb_packet_divide samples as i_ardy.
//  Each command carries the section flags (info/image/statis); the block also flags the end of each frame.
// PARAMETERS
//  FRAME_BYTE_ADDR_WD  32    byte address / length width
//  DATA_WD             256   memory data width, bits; DATA_BYTES = DATA_WD/8
//  BURST_MAX_BYTES     2048  max bytes per command; power of 2, multiple of DATA_BYTES, <= 256*DATA_BYTES
//  BOUNDARY_BYTES      4096  burst must not cross this boundary; power of 2, >= BURST_MAX_BYTES
// PORTS
//  clk            in   1                    clock
//  reset          in   1                    async reset, active high
//  i_fval         in   1                    frame valid from packet divider
//  i_aval         in   1                    request valid
//  i_info_flag    in   1                    request belongs to info section
//  i_image_flag   in   1                    request belongs to image section
//  i_statis_flag  in   1                    request belongs to statistics section
//  iv_rd_addr     in   FRAME_BYTE_ADDR_WD   request start byte address, DATA_BYTES-aligned
//  iv_rd_length   in   FRAME_BYTE_ADDR_WD   request length in bytes
//  o_ardy         out  1                    block can accept a request
//  o_cmd_valid    out  1                    command valid
//  i_cmd_ready    in   1                    command accepted by memory controller
//  ov_cmd_addr    out  FRAME_BYTE_ADDR_WD   command start byte address
//  ov_cmd_len     out  8                    command beats minus 1
//  ov_cmd_flag    out  3                    {statis,image,info} of the parent request
//  o_cmd_last     out  1                    last command of the current request
//  o_frame_done   out  1                    1-cycle pulse: frame ended, all commands issued
// BEHAVIOUR
//  - Reset values:
//      o_ardy=1, o_cmd_valid=0, ov_cmd_addr=0, ov_cmd_len=0, ov_cmd_flag=0, o_cmd_last=0, o_frame_done=0.
//  - FSM states IDLE, CALC, ISSUE.
//  - IDLE: o_ardy=1. A request is accepted when i_aval&o_ardy.
//      On accept: latch addr, length and flags; go to CALC; o_ardy falls the next cycle.
//  - Accepted request with length 0: no command issued; stay IDLE.
//  - CALC: register chunk = min(rem, BURST_MAX_BYTES, BOUNDARY_BYTES - (addr mod BOUNDARY_BYTES)).
//      ov_cmd_len = ceil(chunk/DATA_BYTES)-1; a partial last beat rounds up.
//      o_cmd_last = (chunk >= rem). Go to ISSUE.
//  - ISSUE: o_cmd_valid=1. addr/len/flag/last stay stable until i_cmd_ready.
//      On handshake: addr += chunk; rem -= chunk (saturating at 0).
//      If last: go to IDLE. Otherwise go to CALC.
//  - Timing: first o_cmd_valid 2 cycles after the accept. Each subsequent command 2 cycles after the previous handshake.
//  - o_ardy rises the cycle after the last handshake.
//  - Widths: internal arithmetic at FRAME_BYTE_ADDR_WD+1 bits. Address wrap at 2^FRAME_BYTE_ADDR_WD is not flagged.
//  - Frame end: i_fval is registered; a falling edge sets fall_pend.
//      o_frame_done pulses on the first cycle with state==IDLE, no accept that cycle, and fall_pend=1. The pulse clears fall_pend.
//      A falling edge during an active request is held until that request completes.
//  - i_aval while o_ardy=0: ignored. Upstream must hold the request.
//  - A fval rise and fall on the same sampled cycle is treated as a single fall.
//  - Reset mid-operation: the in-flight request and any pending command are dropped; all outputs return to reset values.
// TESTING
//  - DATA_WD=256, addr 0x0, len 256 -> one command: addr 0x0, len 7, last=1, flag matches input.
//      o_cmd_valid asserts 2 cycles after the accept.
//  - addr 0x0F00, len 0x400 -> two commands: (0x0F00, len 7, last 0), then (0x1000, len 23, last 1).
//  - addr 0x0, len 5000 -> three commands:
//      (0x0, len 63), (0x800, len 63), (0x1000, len 28, last 1).
//  - Hold i_cmd_ready=0 for 10 cycles during ISSUE -> valid, addr, len, last stable.
//      o_ardy stays 0 and a second i_aval is not accepted.
//  - len 0 request, then i_fval fall while idle -> no command issued; o_frame_done pulses exactly once.
//  - i_fval falls mid-request -> o_frame_done pulses only after the last handshake.
//      Assert reset mid-ISSUE -> o_cmd_valid=0 immediately and o_ardy=1.

Source files
------------

// File: rtl/fb_read_cmd_split_if.sv
// Request/command bundle between fb_packet_divide, fb_read_cmd_split and the memory controller.
// master: request source and command sink (drives i_* signals, observes o_*/ov_* signals).
// slave : the splitter itself (observes i_*/iv_* signals, drives o_*/ov_* signals).
interface fb_read_cmd_split_if #(
  parameter int FRAME_BYTE_ADDR_WD = 32
);
  logic                          i_fval;
  logic                          i_aval;
  logic                          i_info_flag;
  logic                          i_image_flag;
  logic                          i_statis_flag;
  logic [FRAME_BYTE_ADDR_WD-1:0] iv_rd_addr;
  logic [FRAME_BYTE_ADDR_WD-1:0] iv_rd_length;
  logic                          o_ardy;
  logic                          o_cmd_valid;
  logic                          i_cmd_ready;
  logic [FRAME_BYTE_ADDR_WD-1:0] ov_cmd_addr;
  logic [7:0]                    ov_cmd_len;
  logic [2:0]                    ov_cmd_flag;
  logic                          o_cmd_last;
  logic                          o_frame_done;

  modport master (
    output i_fval, i_aval, i_info_flag, i_image_flag, i_statis_flag,
           iv_rd_addr, iv_rd_length, i_cmd_ready,
    input  o_ardy, o_cmd_valid, ov_cmd_addr, ov_cmd_len, ov_cmd_flag,
           o_cmd_last, o_frame_done
  );

  modport slave (
    input  i_fval, i_aval, i_info_flag, i_image_flag, i_statis_flag,
           iv_rd_addr, iv_rd_length, i_cmd_ready,
    output o_ardy, o_cmd_valid, ov_cmd_addr, ov_cmd_len, ov_cmd_flag,
           o_cmd_last, o_frame_done
  );
endinterface

// File: rtl/fb_read_cmd_split.sv
// Splits packet read requests into memory bursts (<= BURST_MAX_BYTES, never crossing BOUNDARY_BYTES).
// Latency: first command valid 2 cycles after accept, then 2 cycles after each handshake.
// Backpressure: command fields held until i_cmd_ready; o_ardy low from accept until the cycle after the last handshake.
// Ports: clk, reset (async, active high); bus (slave modport): request in, command out, frame-done pulse out.
module fb_read_cmd_split #(
  parameter int FRAME_BYTE_ADDR_WD = 32,
  parameter int DATA_WD            = 256,
  parameter int BURST_MAX_BYTES    = 2048,
  parameter int BOUNDARY_BYTES     = 4096
) (
  input  logic               clk,
  input  logic               reset,
  fb_read_cmd_split_if.slave bus
);
  localparam int AW         = FRAME_BYTE_ADDR_WD;
  localparam int DATA_BYTES = DATA_WD / 8;
  localparam int BEAT_SH    = $clog2(DATA_BYTES);

  // Arithmetic is one bit wider than the address so a full-range length never overflows.
  localparam logic [AW:0] BURST_MAX = (AW+1)'(BURST_MAX_BYTES);
  localparam logic [AW:0] BOUNDARY  = (AW+1)'(BOUNDARY_BYTES);
  localparam logic [AW:0] BEAT_RND  = (AW+1)'(DATA_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   rem_q, rem_d;
  logic [AW:0]   chunk_q, chunk_d;
  logic [7:0]    len_q, len_d;
  logic [2:0]    flag_q, flag_d;
  logic          last_q, last_d;
  logic          fval_q;
  logic          fall_pend_q, fall_pend_d;

  logic          accept;
  logic          handshake;
  logic          frame_done;
  logic          fall_det;
  logic [AW:0]   room;
  logic [AW:0]   chunk_c;
  logic [AW:0]   beats_c;

  assign accept    = bus.i_aval && (state_q == IDLE);
  assign handshake = (state_q == ISSUE) && bus.i_cmd_ready;

  // Bytes left before the next boundary, then the smallest of the three limits.
  always_comb begin
    room    = BOUNDARY - ({1'b0, addr_q} & (BOUNDARY - 1'b1));
    chunk_c = rem_q;
    if (chunk_c > BURST_MAX) chunk_c = BURST_MAX;
    if (chunk_c > room)      chunk_c = room;
    // Round a partial last beat up to a whole beat.
    beats_c = (chunk_c + BEAT_RND) >> BEAT_SH;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (bus.iv_rd_length != '0)) state_d = CALC;
      CALC:    state_d = ISSUE;
      ISSUE:   if (handshake) state_d = last_q ? IDLE : CALC;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.o_ardy       = (state_q == IDLE);
    bus.o_cmd_valid  = (state_q == ISSUE);
    bus.ov_cmd_addr  = addr_q;
    bus.ov_cmd_len   = len_q;
    bus.ov_cmd_flag  = flag_q;
    bus.o_cmd_last   = last_q;
    bus.o_frame_done = frame_done;
  end

  // ---------------- request / command datapath ----------------
  always_comb begin
    addr_d  = addr_q;
    rem_d   = rem_q;
    chunk_d = chunk_q;
    len_d   = len_q;
    flag_d  = flag_q;
    last_d  = last_q;
    if (accept) begin
      addr_d = bus.iv_rd_addr;
      rem_d  = {1'b0, bus.iv_rd_length};
      flag_d = {bus.i_statis_flag, bus.i_image_flag, bus.i_info_flag};
    end
    if (state_q == CALC) begin
      chunk_d = chunk_c;
      len_d   = 8'(beats_c - 1'b1);
      last_d  = (chunk_c >= rem_q);
    end
    if (handshake) begin
      addr_d = addr_q + AW'(chunk_q);
      rem_d  = (rem_q > chunk_q) ? (rem_q - chunk_q) : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      rem_q   <= '0;
      chunk_q <= '0;
      len_q   <= '0;
      flag_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      chunk_q <= chunk_d;
      len_q   <= len_d;
      flag_q  <= flag_d;
      last_q  <= last_d;
    end
  end

  // ---------------- frame end tracking ----------------
  // A fall seen while a request is in flight stays pending until the FSM is idle again.
  assign fall_det    = fval_q && !bus.i_fval;
  assign frame_done  = (state_q == IDLE) && !accept && fall_pend_q;
  assign fall_pend_d = (fall_pend_q && !frame_done) || fall_det;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fval_q      <= 1'b0;
      fall_pend_q <= 1'b0;
    end else begin
      fval_q      <= bus.i_fval;
      fall_pend_q <= fall_pend_d;
    end
  end
endmodule

// File: tb/tb_fb_read_cmd_split.sv
`timescale 1ns/1ps
module tb_fb_read_cmd_split;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fb_read_cmd_split_if #(.FRAME_BYTE_ADDR_WD(AW)) bus ();

  fb_read_cmd_split #(
    .FRAME_BYTE_ADDR_WD(AW),
    .DATA_WD           (256),
    .BURST_MAX_BYTES   (2048),
    .BOUNDARY_BYTES    (4096)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  flag;
    logic        last;
  } cmd_t;

  cmd_t sb[$];
  cmd_t mon_got, mon_exp;
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0;
  int   fd_cnt = 0, fd_cyc = -1, last_hs_cyc = -1;
  int   rdy_mode = 2;  // 0 random, 1 held low, 2 held high
  bit   ardy_chk = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: walk the request in bursts bounded by max size and boundary room.
  task automatic model(input logic [31:0] a, input logic [31:0] l, input logic [2:0] f);
    longint addr, rem, room, chunk;
    cmd_t c;
    addr = a;
    rem  = l;
    while (rem > 0) begin
      room  = 4096 - (addr % 4096);
      chunk = rem;
      if (chunk > 2048) chunk = 2048;
      if (chunk > room) chunk = room;
      c.addr = addr[31:0];
      c.len  = 8'((chunk + 31) / 32 - 1);
      c.flag = f;
      c.last = (chunk >= rem);
      sb.push_back(c);
      addr = addr + chunk;
      rem  = rem - chunk;
    end
  endtask

  // Ready generator: updates just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.i_cmd_ready = ($urandom_range(0, 3) != 0);
      1:       bus.i_cmd_ready = 1'b0;
      default: bus.i_cmd_ready = 1'b1;
    endcase
  end

  // Monitor: pops the scoreboard on every command handshake.
  always @(negedge clk) begin
    if (reset) begin
      ardy_chk = 1'b0;
    end else begin
      if (ardy_chk) begin
        ardy_chk = 1'b0;
        check(bus.o_ardy === 1'b1, "ardy_after_last", 64'(bus.o_ardy), 64'd1);
      end
      if (bus.o_frame_done === 1'b1) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (bus.o_cmd_valid === 1'b1 && bus.i_cmd_ready === 1'b1) begin
        mon_got = '{bus.ov_cmd_addr, bus.ov_cmd_len, bus.ov_cmd_flag, bus.o_cmd_last};
        check(sb.size() != 0, "cmd_unexpected", 64'(mon_got), 64'd0);
        if (sb.size() != 0) begin
          mon_exp = sb.pop_front();
          check(mon_got === mon_exp, "cmd", 64'(mon_got), 64'(mon_exp));
          if (mon_exp.last) begin
            last_hs_cyc = cyc;
            ardy_chk    = 1'b1;
          end
        end
      end
    end
  end

  // Call at a falling edge; returns at the falling edge after the accept.
  task automatic send_req(input logic [31:0] a, input logic [31:0] l, input logic [2:0] f);
    int n = 0;
    while (bus.o_ardy !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(n < 3000, "req_ardy_timeout", 64'(n), 64'd3000);
    bus.i_aval        = 1'b1;
    bus.iv_rd_addr    = a;
    bus.iv_rd_length  = l;
    bus.i_info_flag   = f[0];
    bus.i_image_flag  = f[1];
    bus.i_statis_flag = f[2];
    @(posedge clk);
    model(a, l, f);
    @(negedge clk);
    bus.i_aval = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(sb.size() == 0 && bus.o_ardy === 1'b1 && bus.o_cmd_valid === 1'b0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(n < 5000, "drain_timeout", 64'(n), 64'd5000);
    @(negedge clk);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (bus.o_cmd_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(n < 100, "valid_timeout", 64'(n), 64'd100);
  endtask

  logic [31:0] ra, rl, s_addr;
  logic [7:0]  s_len;
  logic        s_last;

  initial begin
    bus.i_fval = 1'b0; bus.i_aval = 1'b0; bus.i_info_flag = 1'b0; bus.i_image_flag = 1'b0;
    bus.i_statis_flag = 1'b0; bus.iv_rd_addr = '0; bus.iv_rd_length = '0; bus.i_cmd_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check(bus.o_ardy === 1'b1,       "rst_ardy",  64'(bus.o_ardy), 64'd1);
    check(bus.o_cmd_valid === 1'b0,  "rst_valid", 64'(bus.o_cmd_valid), 64'd0);
    check(bus.ov_cmd_addr === '0,    "rst_addr",  64'(bus.ov_cmd_addr), 64'd0);
    check(bus.ov_cmd_len === '0,     "rst_len",   64'(bus.ov_cmd_len), 64'd0);
    check(bus.ov_cmd_flag === '0,    "rst_flag",  64'(bus.ov_cmd_flag), 64'd0);
    check(bus.o_cmd_last === 1'b0,   "rst_last",  64'(bus.o_cmd_last), 64'd0);
    check(bus.o_frame_done === 1'b0, "rst_fdone", 64'(bus.o_frame_done), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    bus.i_fval = 1'b1;
    repeat (3) @(negedge clk);

    // Single-burst request and its 2-cycle latency.
    rdy_mode = 2;
    send_req(32'h0, 32'd256, 3'b010);
    check(bus.o_cmd_valid === 1'b0, "lat_valid_c1", 64'(bus.o_cmd_valid), 64'd0);
    check(bus.o_ardy === 1'b0,      "lat_ardy_low", 64'(bus.o_ardy), 64'd0);
    @(negedge clk);
    check(bus.o_cmd_valid === 1'b1, "lat_valid_c2", 64'(bus.o_cmd_valid), 64'd1);
    wait_done();

    // Boundary split and multi-burst with partial last beat.
    send_req(32'h0F00, 32'h400, 3'b001);
    wait_done();
    send_req(32'h0, 32'd5000, 3'b100);
    wait_done();

    // Backpressure: fields stable, second request ignored.
    rdy_mode = 1;
    send_req(32'h100, 32'h2000, 3'b011);
    wait_valid();
    s_addr = bus.ov_cmd_addr; s_len = bus.ov_cmd_len; s_last = bus.o_cmd_last;
    bus.i_aval = 1'b1; bus.iv_rd_addr = 32'h5000; bus.iv_rd_length = 32'd64;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check(bus.o_cmd_valid === 1'b1 && bus.ov_cmd_addr === s_addr && bus.ov_cmd_len === s_len &&
            bus.o_cmd_last === s_last, "bp_stable", 64'(bus.ov_cmd_addr), 64'(s_addr));
      check(bus.o_ardy === 1'b0, "bp_ardy_low", 64'(bus.o_ardy), 64'd0);
    end
    bus.i_aval = 1'b0;
    rdy_mode = 0;
    wait_done();

    // Zero-length request, then a frame end while idle.
    fd_cnt = 0;
    send_req(32'h40, 32'd0, 3'b111);
    check(bus.o_ardy === 1'b1, "len0_stay_idle", 64'(bus.o_ardy), 64'd1);
    bus.i_fval = 1'b0;
    repeat (10) @(negedge clk);
    check(fd_cnt == 1, "len0_frame_done_once", 64'(fd_cnt), 64'd1);
    bus.i_fval = 1'b1;
    repeat (3) @(negedge clk);

    // Frame end during an active request is deferred until the last handshake.
    rdy_mode = 1;
    send_req(32'h0, 32'd5000, 3'b010);
    fd_cnt = 0;
    bus.i_fval = 1'b0;
    repeat (8) @(negedge clk);
    check(fd_cnt == 0, "fdone_held_busy", 64'(fd_cnt), 64'd0);
    bus.i_fval = 1'b1;
    rdy_mode = 0;
    wait_done();
    repeat (5) @(negedge clk);
    check(fd_cnt == 1, "fdone_after_req", 64'(fd_cnt), 64'd1);
    check(fd_cyc > last_hs_cyc, "fdone_order", 64'(fd_cyc), 64'(last_hs_cyc));

    // Randomized requests, back-to-back, random ready.
    rdy_mode = 0;
    for (int i = 0; i < 40; i++) begin
      ra = 32'($urandom_range(0, 32'h7FFF)) << 5;
      case ($urandom_range(0, 3))
        0:       rl = 32'($urandom_range(0, 64));
        1:       rl = 32'($urandom_range(1, 2048));
        2:       rl = 32'($urandom_range(2049, 9000));
        default: rl = 32'($urandom_range(0, 8)) * 32'd32;
      endcase
      send_req(ra, rl, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) wait_done();
    end
    wait_done();

    // Reset in the middle of ISSUE drops the command.
    rdy_mode = 1;
    send_req(32'h200, 32'h100, 3'b001);
    wait_valid();
    #2 reset = 1'b1;
    #1;
    check(bus.o_cmd_valid === 1'b0, "rst_mid_valid", 64'(bus.o_cmd_valid), 64'd0);
    check(bus.o_ardy === 1'b1,      "rst_mid_ardy",  64'(bus.o_ardy), 64'd1);
    check(bus.ov_cmd_addr === '0,   "rst_mid_addr",  64'(bus.ov_cmd_addr), 64'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    rdy_mode = 2;
    @(negedge clk);
    send_req(32'h0, 32'd64, 3'b100);
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
